// File: rtl/ctrl_seq.sv
// ctrl_seq -- fetch/decode/execute sequencer for the 8-bit-address,
// 16-bit-data simple computer. Owns every control strobe on the shared
// DATA[15:0] / ADDR[7:0] buses and issues at most one driver per bus per cycle.
//
// Ports:
//   CLK            system clock, all state changes on rising edge
//   AR_N           synchronous active-low reset
//   RUN            run enable, sampled in IDLE and at instruction completion
//   MRDY           memory ready (memory access completes when 1)
//   OPCODE[3:0]    IR[15:12], captured in DECODE only
//   ZF             accumulator-zero flag, used by JZ in EXEC
//   PCC/POA/PLA/POD/PLD  PC increment / PC->ADDR / ADDR->PC / PC->DATA / DATA->PC
//   IRL            IR load from DATA
//   IOA            IR[7:0] -> ADDR
//   ACL / ACO      ACC load from ALU / ACC -> DATA
//   ALUS[1:0]      00 pass, 01 add, 10 sub, 11 pass (return address)
//   MRD / MWR      memory read / write
//   HALTED         high in HALT
//   STATE[2:0]     IDLE=0 FETCH=1 DECODE=2 EXEC=3 EXEC2=4 HALT=5
//
// Build option: SEQ_MRDY_EN enables the MRDY wait-state handshake. When it
// is undefined MRDY is ignored and every memory access takes one cycle.
//
// Handshake: a memory access (FETCH, or EXEC of LDA/STA/ADD/SUB) holds its
// strobes every cycle until a cycle with MRDY=1; that cycle is the one in
// which the transfer happens and the result-side strobes (IRL/PCC, ACL) fire.
//
// All outputs, including STATE, are forced to 0 while AR_N=0.

module ctrl_seq (
  input  logic       CLK,
  input  logic       AR_N,
  input  logic       RUN,
  input  logic       MRDY,
  input  logic [3:0] OPCODE,
  input  logic       ZF,
  output logic       PCC,
  output logic       POA,
  output logic       PLA,
  output logic       POD,
  output logic       PLD,
  output logic       IRL,
  output logic       IOA,
  output logic       ACL,
  output logic       ACO,
  output logic [1:0] ALUS,
  output logic       MRD,
  output logic       MWR,
  output logic       HALTED,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_EXEC2  = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_STA  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_JZ   = 4'h6;
  localparam logic [3:0] OP_JAL  = 4'h7;
  localparam logic [3:0] OP_JR   = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic       rdy;
  logic       done;

  logic pcc_c, poa_c, pla_c, pod_c, pld_c, irl_c, ioa_c, acl_c, aco_c;
  logic mrd_c, mwr_c, halted_c;
  logic [1:0] alus_c;

`ifdef SEQ_MRDY_EN
  assign rdy = MRDY;
`else
  logic unused_mrdy;
  assign unused_mrdy = MRDY;
  assign rdy = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (!AR_N) begin
      state_q <= S_IDLE;
      op_q    <= 4'h0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    done     = 1'b0;
    pcc_c    = 1'b0;
    poa_c    = 1'b0;
    pla_c    = 1'b0;
    pod_c    = 1'b0;
    pld_c    = 1'b0;
    irl_c    = 1'b0;
    ioa_c    = 1'b0;
    acl_c    = 1'b0;
    aco_c    = 1'b0;
    alus_c   = 2'b00;
    mrd_c    = 1'b0;
    mwr_c    = 1'b0;
    halted_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (RUN) state_d = S_FETCH;
      end
      S_FETCH: begin
        // POA presents the pre-increment PC; PCC takes effect on the same edge.
        poa_c = 1'b1;
        mrd_c = 1'b1;
        if (rdy) begin
          irl_c   = 1'b1;
          pcc_c   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        op_d    = OPCODE;
        state_d = (OPCODE == OP_HALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        case (op_q)
          OP_LDA, OP_ADD, OP_SUB: begin
            ioa_c  = 1'b1;
            mrd_c  = 1'b1;
            alus_c = (op_q == OP_ADD) ? 2'b01 :
                     (op_q == OP_SUB) ? 2'b10 : 2'b00;
            acl_c  = rdy;
            done   = rdy;
          end
          OP_STA: begin
            ioa_c = 1'b1;
            aco_c = 1'b1;
            mwr_c = 1'b1;
            done  = rdy;
          end
          OP_JMP: begin
            ioa_c = 1'b1;
            pla_c = 1'b1;
            done  = 1'b1;
          end
          OP_JZ: begin
            ioa_c = ZF;
            pla_c = ZF;
            done  = 1'b1;
          end
          OP_JAL: begin
            // PC already points past JAL: latch it into ACC as the return address.
            pod_c   = 1'b1;
            alus_c  = 2'b11;
            acl_c   = 1'b1;
            state_d = S_EXEC2;
          end
          OP_JR: begin
            aco_c = 1'b1;
            pld_c = 1'b1;
            done  = 1'b1;
          end
          default: done = 1'b1;
        endcase
      end
      S_EXEC2: begin
        ioa_c = 1'b1;
        pla_c = 1'b1;
        done  = 1'b1;
      end
      S_HALT: begin
        halted_c = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (done) state_d = RUN ? S_FETCH : S_IDLE;
  end

  // Reset silences the buses immediately, including an access in progress.
  assign PCC    = pcc_c    & AR_N;
  assign POA    = poa_c    & AR_N;
  assign PLA    = pla_c    & AR_N;
  assign POD    = pod_c    & AR_N;
  assign PLD    = pld_c    & AR_N;
  assign IRL    = irl_c    & AR_N;
  assign IOA    = ioa_c    & AR_N;
  assign ACL    = acl_c    & AR_N;
  assign ACO    = aco_c    & AR_N;
  assign ALUS   = alus_c   & {2{AR_N}};
  assign MRD    = mrd_c    & AR_N;
  assign MWR    = mwr_c    & AR_N;
  assign HALTED = halted_c & AR_N;
  assign STATE  = AR_N ? state_q : S_IDLE;

endmodule
